baud_gen_frac: RTL
==================

// Module: baud_gen_frac
// PURPOSE
//   Programmable fractional baud-tick generator: the successor to the fixed 8x generator.
//   Produces an oversample tick (tick_os) and a bit tick (tick_baud) from one clock.
//   Divisor is integer plus fraction, runtime-loadable, with a resync input for RX start-bit alignment.
//   Sits between the UART register block and the TX/RX FSMs; os_phase gives RX its mid-bit position.
// PARAMETERS
//   CLK_FREQ  100000000  input clock frequency, Hz
//   BAUD      115200     reset-default baud rate
//   OVS       8          oversample ticks per bit; power of 2, 4..16
//   DIV_W     16         integer divisor width
//   FRAC_W    4          fractional divisor width
// PORTS
//   clk        in   1          clock, rising edge
//   rst        in   1          reset; asynchronous, active-high
//   baud_en    in   1          1 = run; 0 = hold counters cleared
//   resync     in   1          1-cycle pulse: restart tick timing from zero
//   cfg_load   in   1          1-cycle pulse: capture div_int/div_frac
//   div_int    in   DIV_W      integer oversample period, clk cycles; valid range >= 2
//   div_frac   in   FRAC_W     fractional period, units of 2^-FRAC_W cycle
//   tick_os    out  1          1-cycle oversample pulse, registered
//   tick_baud  out  1          1-cycle bit pulse, coincident with every OVS-th tick_os
//   os_phase   out  log2(OVS)  oversample index within the current bit; 0 after a tick_baud
//   cfg_pending out 1          captured config is waiting to be applied
//   cfg_err    out  1          1-cycle pulse: cfg_load rejected (div_int < 2)
// BEHAVIOUR
//   Reset: outputs 0, counters 0, acc 0.
//   Reset: active divisor = DEF_INT = floor(CLK_FREQ/(BAUD*OVS)).
//   Reset: DEF_FRAC = floor(CLK_FREQ*2^FRAC_W/(BAUD*OVS)) mod 2^FRAC_W; defaults give 108, 8.
//   Regs: cnt (DIV_W bits), os_cnt (log2 OVS bits), acc (FRAC_W bits).
//   Regs: active and pending div_int/div_frac, pending flag.
//   Period: each OS period has length L = div_int + c.
//   Period: c = carry-out of (acc + div_frac), using the active values.
//   Average period = div_int + div_frac/2^FRAC_W.
//   Running (baud_en=1), per edge when cnt == L-1:
//     cnt<=0; acc<=acc+div_frac mod 2^FRAC_W; tick_os<=1;
//     os_cnt<=os_cnt+1 (wraps at OVS-1);
//     tick_baud<=1 when os_cnt==OVS-1, else 0.
//   Running, any other edge: cnt<=cnt+1; tick_os<=0; tick_baud<=0.
//   First tick_os is high after L enabled edges, same latency convention as the 8x generator.
//   tick_baud is therefore high after OVS enabled periods.
//   os_phase = os_cnt, updated on the same edge as tick_os.
//   baud_en=0: cnt, os_cnt, acc <= 0; ticks <= 0; a pending config is applied on that edge.
//   resync=1 (needs baud_en=1): same clearing as baud_en=0.
//     The next tick_os follows L edges after the resync edge.
//     A pending config is applied on the resync edge.
//     resync has priority over tick generation on the same edge.
//   cfg_load with div_int >= 2: capture into pending, cfg_pending<=1.
//     Apply at the edge that raises tick_baud, so a bit is never stretched mid-way.
//     Also apply on baud_en=0 or resync.
//     On apply: active <= pending, cfg_pending <= 0; the next period uses the new values.
//   cfg_load with div_int < 2: cfg_err<=1 for one cycle; pending and active unchanged.
//   A second cfg_load before apply overwrites the pending value; last load wins.
//   cfg_load together with an apply edge: the new value stays pending until the next boundary.
//   cnt compares against L-1 <= 2^DIV_W-1, so no overflow.
//   div_int = 2^DIV_W-1 with carry gives L = 2^DIV_W, which is legal.
// TESTING
//   Reset, baud_en=1, defaults -> tick_os gaps 108,109,108,109...; 8 os ticks = 868 cycles.
//     -> tick_baud on every 8th tick_os; os_phase counts 1..7,0.
//   cfg_load div_int=10, frac=0 while idle.
//     -> cfg_pending clears next edge; tick_os every 10 cycles; tick_baud every 80.
//   cfg_load div_int=20 at os_phase=3 (running).
//     -> current bit finishes at old rate; cfg_pending=1 until the tick_baud edge; then 20-cycle gaps.
//   cfg_load div_int=1 -> cfg_err single pulse, rates and cfg_pending unchanged.
//   resync at cnt=50, os_phase=5 -> next edge os_phase=0, ticks 0; first tick_os exactly L edges later.
//   rst asserted mid-period, async -> outputs 0 before the next clk edge.
//     -> divisor returns to 108/8; after release, first tick_os after 108 enabled edges.

Source files
------------

// File: rtl/baud_gen_frac.sv
// Fractional baud-tick generator: oversample and bit ticks from a runtime-loadable
// integer+fraction divisor, with resync for RX start-bit alignment.
module baud_gen_frac #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200,
  parameter int OVS      = 8,
  parameter int DIV_W    = 16,
  parameter int FRAC_W   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    baud_en,
  input  logic                    resync,
  input  logic                    cfg_load,
  input  logic [DIV_W-1:0]        div_int,
  input  logic [FRAC_W-1:0]       div_frac,
  output logic                    tick_os,
  output logic                    tick_baud,
  output logic [$clog2(OVS)-1:0]  os_phase,
  output logic                    cfg_pending,
  output logic                    cfg_err
);

  localparam int OS_W = $clog2(OVS);
  localparam longint unsigned SCALED =
    (64'(CLK_FREQ) << FRAC_W) / (64'(BAUD) * 64'(OVS));
  localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(SCALED >> FRAC_W);
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(SCALED);

  logic [DIV_W-1:0]  cnt;
  logic [OS_W-1:0]   os_cnt;
  logic [FRAC_W-1:0] acc;
  logic [DIV_W-1:0]  act_int, pend_int;
  logic [FRAC_W-1:0] act_frac, pend_frac;

  logic [FRAC_W:0]   acc_sum;
  logic [DIV_W:0]    len_m1;
  logic              period_end, bit_end, clear, apply, load_ok;

  // Period length is div_int plus the fractional carry; L-1 always fits in DIV_W bits.
  always_comb begin
    acc_sum    = {1'b0, acc} + {1'b0, act_frac};
    len_m1     = {1'b0, act_int} + {{DIV_W{1'b0}}, acc_sum[FRAC_W]} - (DIV_W+1)'(1);
    period_end = ({1'b0, cnt} == len_m1);
    bit_end    = period_end && (os_cnt == OS_W'(OVS - 1));
    clear      = !baud_en || resync;
    apply      = cfg_pending && (clear || bit_end);
    load_ok    = cfg_load && (div_int >= DIV_W'(2));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      os_cnt      <= '0;
      acc         <= '0;
      tick_os     <= 1'b0;
      tick_baud   <= 1'b0;
      cfg_err     <= 1'b0;
      cfg_pending <= 1'b0;
      act_int     <= DEF_INT;
      act_frac    <= DEF_FRAC;
      pend_int    <= DEF_INT;
      pend_frac   <= DEF_FRAC;
    end else begin
      cfg_err <= cfg_load && !load_ok;

      if (clear) begin
        cnt       <= '0;
        os_cnt    <= '0;
        acc       <= '0;
        tick_os   <= 1'b0;
        tick_baud <= 1'b0;
      end else if (period_end) begin
        cnt       <= '0;
        acc       <= acc_sum[FRAC_W-1:0];
        os_cnt    <= os_cnt + OS_W'(1);
        tick_os   <= 1'b1;
        tick_baud <= bit_end;
      end else begin
        cnt       <= cnt + DIV_W'(1);
        tick_os   <= 1'b0;
        tick_baud <= 1'b0;
      end

      // A load coinciding with an apply edge stays pending for the next boundary.
      if (apply) begin
        act_int  <= pend_int;
        act_frac <= pend_frac;
      end
      if (load_ok) begin
        pend_int    <= div_int;
        pend_frac   <= div_frac;
        cfg_pending <= 1'b1;
      end else if (apply) begin
        cfg_pending <= 1'b0;
      end
    end
  end

  assign os_phase = os_cnt;

endmodule
